prod_bcd_converter: RTL and testbench
=====================================

// Module: prod_bcd_converter
// PURPOSE
// - Downstream of the 8x8 sequential multiplier. Takes its 16-bit product and converts it to packed BCD
//   for the seven-segment display driver.
// - Conversion is sequential double-dabble (shift-and-add-3), one bit per clock.
// - Valid/ready on both sides, so the converter can be stalled by the display path.
// PARAMETERS
// - WIDTH   16  binary input width (matches multiplier product width)
// - DIGITS  5   BCD digits produced; DIGITS*4 >= ceil(WIDTH*0.30103)*4 required, else elaboration $error
// PORTS
// - clk        in   1           system clock, all state updates on rising edge
// - rst_n      in   1           asynchronous, active-low reset
// - in_valid   in   1           bin_in holds a product to convert
// - in_ready   out  1           converter can accept (state IDLE)
// - bin_in     in   WIDTH       unsigned binary value (multiplier C output)
// - out_valid  out  1           bcd_out/nz_mask hold a finished result (state DONE)
// - out_ready  in   1           consumer takes the result
// - bcd_out    out  4*DIGITS    packed BCD; digit 0 (ones) in [3:0]
// - nz_mask    out  DIGITS      bit i = 1 if digit i is significant (leading-zero blanking); bit 0 always 1
// - busy       out  1           high in SHIFT state
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, shift reg/bcd_out=0, nz_mask=1, counter=0, in_ready=1,
//   out_valid=0, busy=0. Deassertion is synchronous to clk.
// - FSM states:
//   - IDLE : in_ready=1. in_valid=1 at an edge captures bin_in, clears BCD accumulator, counter=0, -> SHIFT.
//   - SHIFT: each edge: every BCD digit >=5 gets +3, then {bcd,bin} shifts left 1; counter+1.
//            Iteration with counter==WIDTH-1 -> DONE; result registered into bcd_out/nz_mask on the same edge.
//   - DONE : out_valid=1; bcd_out/nz_mask stable. out_ready=1 at an edge -> IDLE.
// - Latency: accept edge E; out_valid rises after edge E+WIDTH (16 clocks for default). Throughput 1 per WIDTH+2 clocks.
// - Add-3 correction uses the digit value before that cycle's shift, all digits in parallel; no carry between digits.
// - nz_mask[i] = 1 if digit i != 0 or any higher digit != 0; computed when entering DONE; bit 0 forced 1.
// - bin_in is sampled only at the accept edge; later changes are ignored.
// - in_valid is ignored in SHIFT/DONE (in_ready=0); no queueing.
//   - DONE with out_ready=1 and in_valid=1: only the result is consumed; the new input is accepted at the
//     earliest next edge (from IDLE).
// - out_ready held low: DONE persists indefinitely; outputs do not change.
// - Async reset mid-SHIFT or mid-DONE: conversion discarded, outputs return to reset values immediately.
// - Input 0 yields all-zero BCD, nz_mask = 1. Max input 2^WIDTH-1 must convert exactly (no truncation).
// TESTING
// - 0 accepted -> after 16 clk: out_valid=1, bcd_out=20'h00000, nz_mask=5'b00001.
// - 65535 -> bcd_out=20'h65535, nz_mask=5'b11111. 65025 (255*255 from multiplier) -> bcd_out=20'h65025.
// - 1234 -> bcd_out=20'h01234, nz_mask=5'b01111. busy high exactly 16 clocks; in_ready low from accept to hand-off.
// - 7 with out_ready=0 for 10 clocks -> bcd_out=20'h00007 held stable, out_valid held high, in_valid=1 of 99 ignored;
//   raise out_ready -> IDLE, 99 then accepted -> 20'h00099.
// - rst_n pulsed low mid-SHIFT of 4321 -> all outputs at reset values at once; next input 10 -> 20'h00010, nz_mask=5'b00011.
// - Random sweep of 1000 values, out_ready toggling randomly -> each bcd_out matches reference decimal; no lost or duplicated results.

Source files
------------

// File: rtl/prod_bcd_converter_if.sv
// Valid/ready bundle between the multiplier product source, the BCD converter
// and the seven-segment display path.
interface prod_bcd_converter_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     nz_mask;
  logic                  busy;

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, nz_mask, busy
  );

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, nz_mask, busy
  );
endinterface

// File: rtl/prod_bcd_converter.sv
// Sequential double-dabble binary-to-packed-BCD converter, one bit per clock,
// with leading-zero significance mask and valid/ready on both sides.
module prod_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prod_bcd_converter_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // DIGITS must cover ceil(WIDTH*log10(2)) decimal digits
  if (DIGITS * 100000 < WIDTH * 30103) begin : g_digits_check
    $error("prod_bcd_converter: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_bin;
  logic [BW-1:0]     r_bcd;
  logic [BW-1:0]     r_bcd_out;
  logic [DIGITS-1:0] r_nz;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     w_bcd_adj;
  logic [BW-1:0]     w_bcd_shift;
  logic [DIGITS-1:0] w_nz;
  logic              w_last;

  always_comb begin
    w_bcd_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                       : r_bcd[4*i +: 4];
    end
    // top bit of the adjusted accumulator falls off the shift
    w_bcd_shift = BW'({w_bcd_adj, r_bin[WIDTH-1]});
  end

  always_comb begin
    logic        w_any;
    int unsigned j;
    w_any = 1'b0;
    w_nz  = '0;
    j     = 0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      j       = DIGITS - 1 - i;
      w_any   = w_any | (w_bcd_shift[4*j +: 4] != 4'd0);
      w_nz[j] = w_any;
    end
    w_nz[0] = 1'b1;
  end

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.bcd_out   = r_bcd_out;
    bus.nz_mask   = r_nz;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        bus.busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_bcd_out <= '0;
      r_nz      <= DIGITS'(1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_bin <= bus.bin_in;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_bin <= r_bin << 1;
          r_bcd <= w_bcd_shift;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_bcd_out <= w_bcd_shift;
            r_nz      <= w_nz;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_prod_bcd_converter.sv
// Scoreboard bench for prod_bcd_converter: the driver queues expected results on
// accept, a negedge monitor pops and compares on every output hand-off.
module tb_prod_bcd_converter;
  typedef struct packed {
    logic [19:0] bcd;
    logic [4:0]  mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n_got = 0;
  int   rdy_mode = 1;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  prod_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();

  prod_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [19:0] b, input logic [4:0] m);
    exp_t e;
    e.bcd  = b;
    e.mask = m;
    return e;
  endfunction

  function automatic exp_t ref_conv(input int unsigned v);
    exp_t        e;
    int unsigned t;
    logic [4:0]  nz;
    t = v;
    e.bcd = '0;
    for (int i = 0; i < 5; i++) begin
      e.bcd[4*i +: 4] = 4'(t % 10);
      nz[i] = (t % 10) != 0;
      t = t / 10;
    end
    e.mask[4] = nz[4];
    for (int i = 3; i >= 0; i--) e.mask[i] = e.mask[i+1] | nz[i];
    e.mask[0] = 1'b1;
    return e;
  endfunction

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual bcd=%h required=no result", bus.bcd_out);
      end else begin
        e = sb_q.pop_front();
        chk("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
        chk("nz_mask", 32'(bus.nz_mask), 32'(e.mask));
        n_got++;
      end
    end
  end

  task automatic send(input logic [15:0] v, input exp_t e);
    int n = 0;
    bus.bin_in   = v;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual in_ready=%b required=1", bus.in_ready);
    end else begin
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.bin_in   = 16'($urandom);
  endtask

  task automatic measure(input logic [15:0] v, input exp_t e);
    int nbusy = 0;
    int nlow = 0;
    int first = -1;
    send(v, e);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) nbusy++;
      if (bus.in_ready === 1'b0) nlow++;
      if (bus.out_valid === 1'b1 && first < 0) first = k;
    end
    chk("busy_cycles", 32'(nbusy), 32'd16);
    chk("in_ready_low_cycles", 32'(nlow), 32'd17);
    chk("latency", 32'(first), 32'd16);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || bus.in_ready !== 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual pending=%0d required=0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_bcd_out"},   32'(bus.bcd_out),   32'd0);
    chk({tag, "_nz_mask"},   32'(bus.nz_mask),   32'd1);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int unsigned v;
    bus.in_valid = 1'b0;
    bus.bin_in   = '0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    measure(16'd0,     mk(20'h00000, 5'b00001));
    measure(16'd65535, mk(20'h65535, 5'b11111));
    measure(16'd65025, mk(20'h65025, 5'b11111));
    measure(16'd1234,  mk(20'h01234, 5'b01111));
    wait_drain();

    // stalled consumer: result must hold while new input is refused
    rdy_mode = 0;
    send(16'd7, mk(20'h00007, 5'b00001));
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_done", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.bin_in   = 16'd99;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_bcd_out",   32'(bus.bcd_out),   32'h00007);
      chk("stall_nz_mask",   32'(bus.nz_mask),   32'd1);
      chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    rdy_mode = 1;
    send(16'd99, mk(20'h00099, 5'b00011));
    wait_drain();

    // asynchronous reset in the middle of a conversion
    send(16'd4321, mk(20'h04321, 5'b01111));
    repeat (5) @(posedge clk);
    #2;
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd10, mk(20'h00010, 5'b00011));
    wait_drain();

    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      v = $urandom_range(0, 65535);
      send(16'(v), ref_conv(v));
    end
    @(posedge clk);
    #1;
    rdy_mode = 1;
    wait_drain();

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    chk("result_count", 32'(n_got), 32'd1007);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
